mmio_bridge_pipelined: RTL and testbench
========================================

Name: mmio_bridge_pipelined

Overview:
Parametrised, pipelined successor to the team's MMIO slot controller. It sits between the FPro bus from the MicroBlaze MCS and up to NUM_SLOTS peripheral cores (timer, sseg, gpio, ...).
- Decodes the bus address into one-hot slot strobes through a registered request stage.
- Returns read data with a fixed 2-cycle latency and a valid pulse.
- Detects accesses to unmapped or disabled slots and to malformed requests, with a sticky error flag, a saturating error counter and a captured error address.

Parameters:
NUM_SLOTS, 64, number of physical slot ports (1..2**SLOT_BITS)
SLOT_BITS, 6, width of slot index field, mmio_addr[REG_BITS+SLOT_BITS-1:REG_BITS]
REG_BITS, 5, width of per-slot register field, mmio_addr[REG_BITS-1:0]
ADDR_WIDTH, 21, bus address width; bits above REG_BITS+SLOT_BITS are ignored
SLOT_EN_MASK, {NUM_SLOTS{1'b1}}, bit i=0 marks slot i disabled (treated as unmapped)
DEFAULT_RD, 32'hFFFF_FFFF, read data returned for unmapped/disabled/error reads
ERR_CNT_WIDTH, 8, width of saturating error counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
mmio_cs  in  1  bus select
mmio_read  in  1  read request (valid with mmio_cs)
mmio_write  in  1  write request (valid with mmio_cs)
mmio_addr  in  ADDR_WIDTH  word address
mmio_wr_data  in  32  write data
mmio_rd_data  out  32  registered read data
mmio_rd_valid  out  1  one-cycle pulse, mmio_rd_data valid
slot_cs  out  NUM_SLOTS  one-hot slot select
slot_mem_rd  out  NUM_SLOTS  one-hot read strobe
slot_mem_wr  out  NUM_SLOTS  one-hot write strobe
slot_mem_addr  out  [NUM_SLOTS][REG_BITS]  register address, broadcast to all slots
slot_wr_data  out  [NUM_SLOTS][32]  write data, broadcast to all slots
slot_rd_data  in  [NUM_SLOTS][32]  per-slot combinational read data
err_flag  out  1  sticky error indication
err_count  out  ERR_CNT_WIDTH  saturating error count
err_addr  out  ADDR_WIDTH  address of the most recent error
err_clr  in  1  synchronous clear of err_flag/err_count/err_addr

Behaviour:
- Reset (reset=0, async): every output and internal register goes to 0, including mmio_rd_data, mmio_rd_valid, all slot strobes, err_*. Any in-flight request is dropped and no rd_valid is issued for it. Decoding resumes on the first edge after deassertion.
- Stage 0 (cycle N): a request is accepted when mmio_cs=1 and exactly one of read/write is 1. The request is registered (req_v, rd, wr, addr, wr_data). One request per cycle is sustained, with no stalls.
- Stage 1 (N+1): idx = addr slot field.
  - mapped = idx<NUM_SLOTS && SLOT_EN_MASK[idx].
  - If mapped: slot_cs[idx]=1, and slot_mem_rd[idx] or slot_mem_wr[idx]=1, all for exactly one cycle. All other bits are 0.
  - slot_mem_addr and slot_wr_data carry the registered values on every slot, and hold their last value when idle.
- Stage 2 (N+2), reads only:
  - mmio_rd_data = slot_rd_data[idx] sampled at N+1, or DEFAULT_RD if unmapped. mmio_rd_valid=1 for one cycle.
  - mmio_rd_data holds its value until the next read completes.
- Writes never produce rd_valid.
- Error events, each evaluated in stage 1:
  - a mapped-check failure on a read or write;
  - mmio_cs=1 with read=1 and write=1 simultaneously (no strobes; treated as a read for rd_valid, returns DEFAULT_RD).
- mmio_cs=1 with neither read nor write is ignored and is not an error.
- On an error event: err_flag<=1; err_count<=err_count+1, saturating at all-ones; err_addr<=registered addr.
- err_clr=1: clears err_flag, err_count and err_addr on the next edge.
  - If an error event occurs in the same cycle as err_clr: err_flag=1, err_count=1, err_addr=new address.
- Back-to-back reads to different slots return data in issue order, each 2 cycles after its request.
- A write followed by a read to the same register in consecutive cycles: the write strobe precedes the read strobe by one cycle. The slot therefore returns post-write data.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles with mmio_cs toggling -> all strobes 0, mmio_rd_valid never 1, err_count=0.
- Write slot 5, reg 2, data 0x0000_00A5 at cycle N -> slot_cs[5]=slot_mem_wr[5]=1 only at N+1, slot_mem_addr=2, slot_wr_data=0xA5, no rd_valid.
- Back-to-back reads: slot 0 (slot_rd_data[0]=0x1111_1111), then slot 4 (0x4444_4444) on consecutive cycles -> rd_valid at N+2 and N+3 with 0x1111_1111 then 0x4444_4444.
- Unmapped read: NUM_SLOTS=8, address slot field 12 -> no strobes, rd_data=0xFFFF_FFFF at N+2, err_flag=1, err_count=1, err_addr=requested address.
- Error saturation and clear: 300 disabled-slot writes (SLOT_EN_MASK[3]=0), then err_clr asserted together with one more error -> err_count reaches 255; after the clear err_count=1, err_flag=1.
- Reset mid-read: issue a read at N, assert reset at N+1 -> mmio_rd_valid stays 0 and mmio_rd_data=0 after reset.

Source files
------------

// File: rtl/mmio_bridge_pipelined.sv
// mmio_bridge_pipelined
// Pipelined FPro bus to MMIO slot bridge. The request is registered on the
// cycle it is presented, decoded into one-hot slot strobes on the following
// cycle, and read data is registered one cycle later. The result is a fixed
// two-cycle read latency with no stalls. Accesses to unmapped or disabled
// slots, and requests asserting read and write together, raise a sticky
// error flag, bump a saturating counter and capture the offending address.
module mmio_bridge_pipelined #(
    parameter int                    NUM_SLOTS     = 64,
    parameter int                    SLOT_BITS     = 6,
    parameter int                    REG_BITS      = 5,
    parameter int                    ADDR_WIDTH    = 21,
    parameter logic [NUM_SLOTS-1:0]  SLOT_EN_MASK  = {NUM_SLOTS{1'b1}},
    parameter logic [31:0]           DEFAULT_RD    = 32'hFFFF_FFFF,
    parameter int                    ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    // FPro bus side
    input  logic                     mmio_cs,
    input  logic                     mmio_read,
    input  logic                     mmio_write,
    input  logic [ADDR_WIDTH-1:0]    mmio_addr,
    input  logic [31:0]              mmio_wr_data,
    output logic [31:0]              mmio_rd_data,
    output logic                     mmio_rd_valid,
    // slot side
    output logic [NUM_SLOTS-1:0]     slot_cs,
    output logic [NUM_SLOTS-1:0]     slot_mem_rd,
    output logic [NUM_SLOTS-1:0]     slot_mem_wr,
    output logic [REG_BITS-1:0]      slot_mem_addr [NUM_SLOTS],
    output logic [31:0]              slot_wr_data  [NUM_SLOTS],
    input  logic [31:0]              slot_rd_data  [NUM_SLOTS],
    // error reporting
    output logic                     err_flag,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    err_addr,
    input  logic                     err_clr
);

    localparam int SLOT_LSB = REG_BITS;
    localparam int SLOT_MSB = REG_BITS + SLOT_BITS - 1;
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // Stage 0: registered request
    // ------------------------------------------------------------------
    logic                   req_v_q,   req_v_d;
    logic                   rd_q,      rd_d;
    logic                   wr_q,      wr_d;
    logic                   bad_q,     bad_d;
    logic [ADDR_WIDTH-1:0]  addr_q,    addr_d;
    logic [31:0]            wr_data_q, wr_data_d;

    // ------------------------------------------------------------------
    // Stage 2: read return and error state
    // ------------------------------------------------------------------
    logic                     rd_valid_q,  rd_valid_d;
    logic [31:0]              rd_data_q,   rd_data_d;
    logic                     err_flag_q,  err_flag_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0]    err_addr_q,  err_addr_d;

    // Stage 1 decode signals
    logic [SLOT_BITS-1:0]  slot_idx;
    logic [NUM_SLOTS-1:0]  slot_hit;
    logic                  mapped;
    logic                  strobe_en;
    logic                  err_event;
    logic [31:0]           rd_mux;

    // Capture a request when the bus selects us with at least one of read or
    // write. Read+write together is captured as a malformed read so it still
    // returns DEFAULT_RD and gets reported, but never strobes a slot. The
    // address and write data hold their last value while the bus is idle.
    always_comb begin
        req_v_d   = mmio_cs & (mmio_read | mmio_write);
        rd_d      = req_v_d & mmio_read;
        wr_d      = req_v_d & mmio_write & ~mmio_read;
        bad_d     = req_v_d & mmio_read & mmio_write;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        if (req_v_d) begin
            addr_d    = mmio_addr;
            wr_data_d = mmio_wr_data;
        end
    end

    // Stage 0 request register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_v_q   <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            bad_q     <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
        end else begin
            req_v_q   <= req_v_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            bad_q     <= bad_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: slot decode
    // ------------------------------------------------------------------
    // Address bits above the slot field are ignored by the decode but kept
    // in addr_q so the full address can be captured on an error.
    assign slot_idx = addr_q[SLOT_MSB:SLOT_LSB];

    // One comparator per physical slot. An index at or beyond NUM_SLOTS
    // matches no comparator, so it reads as unmapped without a range check.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_dec
            localparam logic [SLOT_BITS-1:0] IDX = SLOT_BITS'(gi);
            assign slot_hit[gi]      = (slot_idx == IDX) && SLOT_EN_MASK[gi];
            assign slot_mem_addr[gi] = addr_q[REG_BITS-1:0];
            assign slot_wr_data[gi]  = wr_data_q;
        end
    endgenerate

    assign mapped    = |slot_hit;
    assign strobe_en = req_v_q & ~bad_q;
    assign err_event = req_v_q & (bad_q | ~mapped);

    assign slot_cs     = strobe_en ? slot_hit : '0;
    assign slot_mem_rd = rd_q      ? slot_cs  : '0;
    assign slot_mem_wr = wr_q      ? slot_cs  : '0;

    // AND-OR read mux driven by the one-hot hit vector; all zero when unmapped.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_hit[i]) begin
                rd_mux = rd_mux | slot_rd_data[i];
            end
        end
    end

    // Read return: sample the selected slot during stage 1 and present it a
    // cycle later. The data register only moves when a read completes.
    always_comb begin
        rd_valid_d = req_v_q & rd_q;
        rd_data_d  = rd_data_q;
        if (req_v_q && rd_q) begin
            rd_data_d = (mapped && !bad_q) ? rd_mux : DEFAULT_RD;
        end
    end

    // Error bookkeeping. A new error wins over a simultaneous clear, so the
    // counter restarts at one instead of being lost.
    always_comb begin
        err_flag_d  = err_flag_q;
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        if (err_event) begin
            err_flag_d = 1'b1;
            err_addr_d = addr_q;
            if (err_clr) begin
                err_count_d = CNT_ONE;
            end else if (err_count_q != CNT_MAX) begin
                err_count_d = err_count_q + CNT_ONE;
            end
        end else if (err_clr) begin
            err_flag_d  = 1'b0;
            err_count_d = '0;
            err_addr_d  = '0;
        end
    end

    // Stage 2 read return and error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else begin
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign mmio_rd_data  = rd_data_q;
    assign mmio_rd_valid = rd_valid_q;
    assign err_flag      = err_flag_q;
    assign err_count     = err_count_q;
    assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_mmio_bridge_pipelined.sv
// Testbench for mmio_bridge_pipelined: 8 slots, slot 3 disabled. Slots are
// modelled as small register files. Expected read data goes into a
// scoreboard queue when a read is issued and is compared when rd_valid
// pulses. Strobes and error outputs are compared every cycle against a
// reference model kept by the driver.
module tb_mmio_bridge_pipelined;

    localparam int          NS      = 8;
    localparam logic [7:0]  EN_MASK = 8'b1111_0111;
    localparam logic [31:0] DEF_RD  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mmio_cs = 1'b0, mmio_read = 1'b0, mmio_write = 1'b0;
    logic [20:0] mmio_addr = '0;
    logic [31:0] mmio_wr_data = '0;
    logic [31:0] mmio_rd_data;
    logic        mmio_rd_valid;
    logic [NS-1:0] slot_cs, slot_mem_rd, slot_mem_wr;
    logic [4:0]  slot_mem_addr [NS];
    logic [31:0] slot_wr_data  [NS];
    logic [31:0] slot_rd_data  [NS];
    logic        err_flag;
    logic [7:0]  err_count;
    logic [20:0] err_addr;
    logic        err_clr = 1'b0;

    mmio_bridge_pipelined #(
        .NUM_SLOTS(NS), .SLOT_BITS(6), .REG_BITS(5), .ADDR_WIDTH(21),
        .SLOT_EN_MASK(EN_MASK), .DEFAULT_RD(DEF_RD), .ERR_CNT_WIDTH(8)
    ) dut (
        .clk(clk), .reset(rst_n),
        .mmio_cs(mmio_cs), .mmio_read(mmio_read), .mmio_write(mmio_write),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
        .mmio_rd_data(mmio_rd_data), .mmio_rd_valid(mmio_rd_valid),
        .slot_cs(slot_cs), .slot_mem_rd(slot_mem_rd), .slot_mem_wr(slot_mem_wr),
        .slot_mem_addr(slot_mem_addr), .slot_wr_data(slot_wr_data),
        .slot_rd_data(slot_rd_data),
        .err_flag(err_flag), .err_count(err_count), .err_addr(err_addr),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input int s, input int r);
        logic [31:0] base;
        base = (s == 0) ? 32'h1111_1111 : 32'h1111_1111 * s;
        return base ^ (32'(r) << 8);
    endfunction

    // Peripheral model: register files written by the strobes, read combinationally
    logic [31:0] pmem [NS][32];
    always @(posedge clk) begin
        for (int s = 0; s < NS; s++) begin
            for (int r = 0; r < 32; r++) begin
                if (!rst_n) pmem[s][r] <= init_val(s, r);
                else if (slot_mem_wr[s] && slot_mem_addr[s] == 5'(r)) pmem[s][r] <= slot_wr_data[s];
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NS; s++) slot_rd_data[s] = pmem[s][slot_mem_addr[s]];
    end

    // Reference model state
    typedef struct { logic [31:0] data; int due; } rd_exp_t;
    rd_exp_t     rdq[$];
    logic [31:0] shadow [NS][32];
    logic [NS-1:0] exp_cs, exp_rd, exp_wr;
    int          exp_idx;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic        m_flag;
    logic [7:0]  m_cnt;
    logic [20:0] m_eaddr;
    logic        err_pend;
    logic [20:0] pend_addr;

    task automatic reset_model();
        exp_cs = '0; exp_rd = '0; exp_wr = '0; exp_idx = 0; exp_reg = '0; exp_data = '0;
        m_flag = 1'b0; m_cnt = '0; m_eaddr = '0;
        err_pend = 1'b0; pend_addr = '0;
        rdq.delete();
        for (int s = 0; s < NS; s++)
            for (int r = 0; r < 32; r++) shadow[s][r] = init_val(s, r);
    endtask

    // One bus cycle: check what the previous cycle should have produced, then drive
    task automatic drive(input logic cs, input logic rd, input logic wr,
                         input logic [20:0] addr, input logic [31:0] data, input logic clr);
        int idx, rg;
        logic mapped;
        @(negedge clk);
        check("slot_cs", 64'(slot_cs), 64'(exp_cs));
        check("slot_mem_rd", 64'(slot_mem_rd), 64'(exp_rd));
        check("slot_mem_wr", 64'(slot_mem_wr), 64'(exp_wr));
        if (exp_cs != '0) begin
            check("slot_mem_addr", 64'(slot_mem_addr[exp_idx]), 64'(exp_reg));
            if (exp_wr != '0) check("slot_wr_data", 64'(slot_wr_data[exp_idx]), 64'(exp_data));
        end
        check("err_flag", 64'(err_flag), 64'(m_flag));
        check("err_count", 64'(err_count), 64'(m_cnt));
        check("err_addr", 64'(err_addr), 64'(m_eaddr));

        mmio_cs = cs; mmio_read = rd; mmio_write = wr;
        mmio_addr = addr; mmio_wr_data = data; err_clr = clr;

        // error state after the coming edge
        if (err_pend) begin
            m_flag  = 1'b1;
            m_eaddr = pend_addr;
            m_cnt   = clr ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1);
        end else if (clr) begin
            m_flag = 1'b0; m_cnt = '0; m_eaddr = '0;
        end

        idx = int'(addr[10:5]);
        rg  = int'(addr[4:0]);
        mapped = 1'b0;
        for (int s = 0; s < NS; s++) if (s == idx) mapped = EN_MASK[s];

        exp_cs = '0; exp_rd = '0; exp_wr = '0;
        if (cs && (rd ^ wr) && mapped) begin
            exp_cs[idx] = 1'b1;
            if (rd) exp_rd[idx] = 1'b1;
            else    exp_wr[idx] = 1'b1;
            exp_idx = idx; exp_reg = addr[4:0]; exp_data = data;
        end
        if (cs && rd) begin
            rd_exp_t e;
            e.data = (!wr && mapped) ? shadow[idx][rg] : DEF_RD;
            e.due  = cyc + 2;
            rdq.push_back(e);
        end
        if (cs && wr && !rd && mapped) shadow[idx][rg] = data;
        err_pend  = cs && (rd || wr) && ((rd && wr) || !mapped);
        pend_addr = addr;
        if (cs && (rd || wr))
            $display("[%0d] issue rd=%0b wr=%0b slot=%0d reg=%0d data=0x%08h clr=%0b", cyc, rd, wr, idx, rg, data, clr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    function automatic logic [20:0] mk_addr(input int slot, input int rg);
        return 21'((slot << 5) | rg);
    endfunction

    // Read-return monitor
    rd_exp_t got_e;
    always @(negedge clk) begin
        if (rst_n && mmio_rd_valid) begin
            if (rdq.size() == 0) begin
                check("rdq_depth_on_valid", 64'(rdq.size()), 64'd1);
            end else begin
                got_e = rdq.pop_front();
                check("rd_data", 64'(mmio_rd_data), 64'(got_e.data));
                check("rd_latency", 64'(cyc), 64'(got_e.due));
                $display("[%0d] read return data=0x%08h", cyc, mmio_rd_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int slot, rg, op;
        logic cs;
        reset_model();

        // Reset held low with bus activity
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mmio_cs = ~mmio_cs; mmio_read = 1'b1; mmio_addr = mk_addr(1, 1);
            check("rst_slot_cs", 64'(slot_cs), 64'd0);
            check("rst_rd_valid", 64'(mmio_rd_valid), 64'd0);
            check("rst_err_count", 64'(err_count), 64'd0);
        end
        @(negedge clk);
        mmio_cs = 1'b0; mmio_read = 1'b0; mmio_addr = '0;
        rst_n = 1'b1;

        // Write slot 5 reg 2
        drive(1'b1, 1'b0, 1'b1, mk_addr(5, 2), 32'h0000_00A5, 1'b0);
        idle(2);

        // Back-to-back reads of slot 0 and slot 4
        drive(1'b1, 1'b1, 1'b0, mk_addr(0, 0), '0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, mk_addr(4, 0), '0, 1'b0);
        idle(3);

        // Unmapped slot 12, upper address bits set
        drive(1'b1, 1'b1, 1'b0, 21'h10000 | mk_addr(12, 1), '0, 1'b0);
        idle(3);

        // Write then read the same register on consecutive cycles
        drive(1'b1, 1'b0, 1'b1, mk_addr(2, 7), 32'hDEAD_BEEF, 1'b0);
        drive(1'b1, 1'b1, 1'b0, mk_addr(2, 7), '0, 1'b0);
        idle(3);

        // Select with neither read nor write: ignored
        drive(1'b1, 1'b0, 1'b0, mk_addr(12, 0), '0, 1'b0);
        idle(2);

        // Read and write together: malformed
        drive(1'b1, 1'b1, 1'b1, mk_addr(6, 3), 32'h1234_5678, 1'b0);
        idle(3);

        // Disabled slot writes to saturate the counter
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, 1'b1, mk_addr(3, i % 32), 32'(i), 1'b0);
        idle(2);
        drive(1'b1, 1'b0, 1'b1, mk_addr(3, 9), 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);   // clear together with the error
        idle(2);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);   // plain clear
        idle(2);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            cs   = ($urandom_range(0, 7) != 0);
            op   = int'($urandom_range(0, 7));
            slot = int'($urandom_range(0, 15));
            rg   = int'($urandom_range(0, 3));
            drive(cs, (op <= 2) || (op == 6), (op >= 3 && op <= 6), mk_addr(slot, rg),
                  $urandom, ($urandom_range(0, 9) == 0));
        end
        idle(3);

        // Reset during an in-flight read
        drive(1'b1, 1'b1, 1'b0, mk_addr(4, 1), '0, 1'b0);
        idle(1);
        rst_n = 1'b0;
        reset_model();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_rd_valid", 64'(mmio_rd_valid), 64'd0);
        end
        check("midrst_rd_data", 64'(mmio_rd_data), 64'd0);
        rst_n = 1'b1;
        idle(3);
        drive(1'b1, 1'b1, 1'b0, mk_addr(4, 1), '0, 1'b0);
        idle(4);

        check("rdq_empty", 64'(rdq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
